// File: rtl/imem_stream.sv
// Simple-dual-port instruction store: burst loader on the write side, and a random-access
// path plus a back-pressured sequential stream path sharing a single read port.
module imem_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_ld_start,
  input  logic [ADDR_WIDTH-1:0] i_ld_base,
  input  logic                  i_ld_valid,
  input  logic [DATA_WIDTH-1:0] i_ld_data,
  output logic [ADDR_WIDTH:0]   o_ld_count,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_st_start,
  input  logic [ADDR_WIDTH-1:0] i_st_addr,
  input  logic [LEN_WIDTH-1:0]  i_st_len,
  output logic                  o_st_valid,
  input  logic                  i_st_ready,
  output logic [DATA_WIDTH-1:0] o_st_data,
  output logic                  o_st_last,
  output logic                  o_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1'b1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1'b1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = {LEN_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } st_state_e;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_r;
  logic [ADDR_WIDTH-1:0] ld_addr_s;
  logic [ADDR_WIDTH-1:0] wptr_nxt_s;
  logic [ADDR_WIDTH:0]   ld_count_r;
  logic [ADDR_WIDTH:0]   ld_cnt_base_s;
  logic [ADDR_WIDTH:0]   ld_count_nxt_s;

  st_state_e             state_r;
  st_state_e             state_nxt_s;
  logic [ADDR_WIDTH-1:0] raddr_r;
  logic [ADDR_WIDTH-1:0] raddr_nxt_s;
  logic [LEN_WIDTH-1:0]  remaining_r;
  logic [LEN_WIDTH-1:0]  remaining_nxt_s;
  logic                  busy_r;

  logic [ADDR_WIDTH-1:0] rd_addr_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  issue_s;
  logic                  issue_last_s;
  logic                  pop_s;
  logic [1:0]            fifo_count_s;

  logic                  rd_valid_r;
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Two-entry FIFO kept as a head register (drives the outputs) plus one skid entry.
  logic                  st_valid_r;
  logic [DATA_WIDTH-1:0] st_data_r;
  logic                  st_last_r;
  logic                  skid_valid_r;
  logic [DATA_WIDTH-1:0] skid_data_r;
  logic                  skid_last_r;

  // Loader address/count selection; a start pulse rebases before the same-cycle write.
  always_comb begin
    ld_addr_s     = i_ld_start ? i_ld_base : wptr_r;
    ld_cnt_base_s = i_ld_start ? {(ADDR_WIDTH+1){1'b0}} : ld_count_r;
    if (i_ld_valid) begin
      wptr_nxt_s     = ld_addr_s + ADDR_ONE;
      ld_count_nxt_s = (ld_cnt_base_s == CNT_MAX) ? CNT_MAX : ld_cnt_base_s + CNT_ONE;
    end else begin
      wptr_nxt_s     = ld_addr_s;
      ld_count_nxt_s = ld_cnt_base_s;
    end
  end

  // Loader pointer and word counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_r     <= {ADDR_WIDTH{1'b0}};
      ld_count_r <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      wptr_r     <= wptr_nxt_s;
      ld_count_r <= ld_count_nxt_s;
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && i_ld_valid) begin
      mem_r[ld_addr_s] <= i_ld_data;
    end
  end

  // Shared read port: random requests win, stream issues only with a free FIFO slot.
  always_comb begin
    fifo_count_s = {1'b0, st_valid_r} + {1'b0, skid_valid_r};
    issue_s      = (state_r == ST_ISSUE) && !i_rd_req && (fifo_count_s < 2'd2);
    issue_last_s = (remaining_r == LEN_ONE);
    pop_s        = st_valid_r && i_st_ready;
    rd_addr_s    = i_rd_req ? i_rd_addr : raddr_r;
    rd_word_s    = mem_r[rd_addr_s];
  end

  // Stream FSM next-state and address/length bookkeeping.
  always_comb begin
    state_nxt_s     = state_r;
    raddr_nxt_s     = raddr_r;
    remaining_nxt_s = remaining_r;
    case (state_r)
      ST_IDLE: begin
        if (i_st_start && (i_st_len != LEN_ZERO)) begin
          raddr_nxt_s     = i_st_addr;
          remaining_nxt_s = i_st_len;
          state_nxt_s     = ST_ISSUE;
        end else begin
          state_nxt_s     = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (issue_s) begin
          raddr_nxt_s     = raddr_r + ADDR_ONE;
          remaining_nxt_s = remaining_r - LEN_ONE;
          state_nxt_s     = issue_last_s ? ST_DRAIN : ST_ISSUE;
        end else begin
          state_nxt_s     = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (fifo_count_s == 2'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Stream FSM state register and registered busy flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      raddr_r     <= {ADDR_WIDTH{1'b0}};
      remaining_r <= LEN_ZERO;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      raddr_r     <= raddr_nxt_s;
      remaining_r <= remaining_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  // Random read response; data holds between requests.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      rd_valid_r <= i_rd_req;
      if (i_rd_req) begin
        rd_data_r <= rd_word_s;
      end
    end
  end

  // Stream FIFO: issued words land one cycle later; the credit check prevents overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_valid_r   <= 1'b0;
      st_data_r    <= {DATA_WIDTH{1'b0}};
      st_last_r    <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= {DATA_WIDTH{1'b0}};
      skid_last_r  <= 1'b0;
    end else begin
      case ({issue_s, pop_s})
        2'b10: begin
          if (!st_valid_r) begin
            st_valid_r <= 1'b1;
            st_data_r  <= rd_word_s;
            st_last_r  <= issue_last_s;
          end else begin
            skid_valid_r <= 1'b1;
            skid_data_r  <= rd_word_s;
            skid_last_r  <= issue_last_s;
          end
        end
        2'b01: begin
          if (skid_valid_r) begin
            st_data_r    <= skid_data_r;
            st_last_r    <= skid_last_r;
            skid_valid_r <= 1'b0;
          end else begin
            st_valid_r <= 1'b0;
          end
        end
        2'b11: begin
          if (skid_valid_r) begin
            st_data_r   <= skid_data_r;
            st_last_r   <= skid_last_r;
            skid_data_r <= rd_word_s;
            skid_last_r <= issue_last_s;
          end else begin
            st_data_r <= rd_word_s;
            st_last_r <= issue_last_s;
          end
        end
        default: begin
          st_valid_r <= st_valid_r;
        end
      endcase
    end
  end

  assign o_ld_count = ld_count_r;
  assign o_rd_valid = rd_valid_r;
  assign o_rd_data  = rd_data_r;
  assign o_st_valid = st_valid_r;
  assign o_st_data  = st_data_r;
  assign o_st_last  = st_last_r;
  assign o_busy     = busy_r;

endmodule

// File: tb/tb_imem_stream.sv
// Scoreboard bench for imem_stream: a reference memory model feeds expected-value queues
// for the random-read and stream paths; a negedge monitor pops and compares.
module tb_imem_stream;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int LW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } st_item_t;

  logic          clk;
  logic          reset;
  logic          i_ld_start;
  logic [AW-1:0] i_ld_base;
  logic          i_ld_valid;
  logic [DW-1:0] i_ld_data;
  logic [AW:0]   o_ld_count;
  logic          i_rd_req;
  logic [AW-1:0] i_rd_addr;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic          i_st_start;
  logic [AW-1:0] i_st_addr;
  logic [LW-1:0] i_st_len;
  logic          o_st_valid;
  logic          i_st_ready;
  logic [DW-1:0] o_st_data;
  logic          o_st_last;
  logic          o_busy;

  imem_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .i_ld_start(i_ld_start), .i_ld_base(i_ld_base), .i_ld_valid(i_ld_valid),
    .i_ld_data(i_ld_data), .o_ld_count(o_ld_count),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .i_st_start(i_st_start), .i_st_addr(i_st_addr), .i_st_len(i_st_len),
    .o_st_valid(o_st_valid), .i_st_ready(i_st_ready), .o_st_data(o_st_data),
    .o_st_last(o_st_last), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  int            st_xfers = 0;
  logic          rd_req_d = 1'b0;
  logic [DW-1:0] model_mem [1 << AW];
  logic [DW-1:0] rd_exp_q [$];
  st_item_t      st_exp_q [$];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected o_rd_valid: one cycle after each sampled request.
  always @(posedge clk) rd_req_d <= reset ? i_rd_req : 1'b0;

  // Monitor: compare both read paths against the scoreboard away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check_val("rd_valid", {63'd0, o_rd_valid}, {63'd0, rd_req_d});
      if (o_rd_valid) begin
        if (rd_exp_q.size() == 0) begin
          check_val("rd_unexpected", 64'(rd_exp_q.size()), 64'd1);
        end else begin
          check_val("rd_data", {32'd0, o_rd_data}, {32'd0, rd_exp_q.pop_front()});
        end
      end
      if (o_st_valid) begin
        if (st_exp_q.size() == 0) begin
          check_val("st_unexpected", 64'(st_exp_q.size()), 64'd1);
        end else begin
          check_val("st_data", {32'd0, o_st_data}, {32'd0, st_exp_q[0].data});
          check_val("st_last", {63'd0, o_st_last}, {63'd0, st_exp_q[0].last});
          if (i_st_ready) begin
            void'(st_exp_q.pop_front());
            st_xfers++;
          end
        end
      end
    end
  end

  task automatic load(input logic [AW-1:0] base, input int n, input logic [DW-1:0] first,
                      input bit separate_start);
    logic [AW-1:0] a;
    if (separate_start) begin
      i_ld_start = 1'b1; i_ld_base = base; i_ld_valid = 1'b0;
      tick();
    end
    for (int i = 0; i < n; i++) begin
      a = base + AW'(i);
      i_ld_start = (!separate_start && i == 0);
      i_ld_base  = base;
      i_ld_valid = 1'b1;
      i_ld_data  = first + DW'(i);
      model_mem[a] = i_ld_data;
      tick();
    end
    i_ld_start = 1'b0;
    i_ld_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] addr);
    i_rd_req  = 1'b1;
    i_rd_addr = addr;
    rd_exp_q.push_back(model_mem[addr]);
    tick();
    i_rd_req  = 1'b0;
  endtask

  task automatic stream_start(input logic [AW-1:0] addr, input int len);
    st_item_t it;
    for (int i = 0; i < len; i++) begin
      it.data = model_mem[addr + AW'(i)];
      it.last = (i == len - 1);
      st_exp_q.push_back(it);
    end
    i_st_start = 1'b1;
    i_st_addr  = addr;
    i_st_len   = LW'(len);
    tick();
    i_st_start = 1'b0;
  endtask

  // Wait (bounded) for the scoreboard to drain, then check o_busy falls one cycle later.
  task automatic wait_drain(input string tag, input bit toggle);
    int n;
    n = 0;
    while (st_exp_q.size() != 0 && n < 300) begin
      if (toggle) i_st_ready = (n % 4 == 0) || (n % 4 == 3);
      tick();
      n++;
    end
    i_st_ready = 1'b1;
    check_val({tag, "_drained"}, 64'(st_exp_q.size()), 64'd0);
    check_val({tag, "_busy_tail"}, {63'd0, o_busy}, 64'd1);
    tick();
    check_val({tag, "_busy_off"}, {63'd0, o_busy}, 64'd0);
    check_val({tag, "_valid_off"}, {63'd0, o_st_valid}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base_x;
    reset = 1'b0; i_ld_start = 1'b0; i_ld_base = '0; i_ld_valid = 1'b0; i_ld_data = '0;
    i_rd_req = 1'b0; i_rd_addr = '0; i_st_start = 1'b0; i_st_addr = '0; i_st_len = '0;
    i_st_ready = 1'b1;
    tick(); tick();
    check_val("rst_ld_count", 64'(o_ld_count), 64'd0);
    check_val("rst_rd_valid", {63'd0, o_rd_valid}, 64'd0);
    check_val("rst_rd_data", {32'd0, o_rd_data}, 64'd0);
    check_val("rst_st_valid", {63'd0, o_st_valid}, 64'd0);
    check_val("rst_st_data", {32'd0, o_st_data}, 64'd0);
    check_val("rst_st_last", {63'd0, o_st_last}, 64'd0);
    check_val("rst_busy", {63'd0, o_busy}, 64'd0);
    reset = 1'b1;
    tick();

    // Fill the whole store plus two more words: count must saturate at depth.
    load(7'd0, 130, 32'h1000, 1'b0);
    check_val("ld_saturate", 64'(o_ld_count), 64'd128);

    // Loader with a separate start pulse, then read back 5..8.
    load(7'd5, 4, 32'hA0, 1'b1);
    check_val("ld_count4", 64'(o_ld_count), 64'd4);
    for (int i = 5; i <= 8; i++) rd(AW'(i));
    tick();

    // Loader wrap past the top of the store.
    load(7'd126, 3, 32'hB0, 1'b0);
    check_val("ld_count_wrap", 64'(o_ld_count), 64'd3);
    rd(7'd126); rd(7'd127); rd(7'd0); rd(7'd1);
    tick();

    // Stream with ready held: first word at N+2, then one word per cycle.
    i_st_ready = 1'b1;
    stream_start(7'd5, 4);
    check_val("st_lat_n1_valid", {63'd0, o_st_valid}, 64'd0);
    check_val("st_lat_n1_busy", {63'd0, o_busy}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("st_continuous", {63'd0, o_st_valid}, 64'd1);
    end
    wait_drain("st_ready", 1'b0);

    // Same stream under a 1,0,0,1 ready pattern.
    stream_start(7'd5, 4);
    wait_drain("st_toggle", 1'b1);

    // Contention: random reads for three cycles in the middle of an 8-word stream.
    load(7'd40, 8, 32'hD0, 1'b0);
    stream_start(7'd40, 8);
    tick(); tick();
    for (int i = 0; i < 3; i++) rd(AW'(5 + i));
    wait_drain("contention", 1'b0);
    check_val("contention_rd_done", 64'(rd_exp_q.size()), 64'd0);

    // Read-during-write collision returns old data; the following read sees the new word.
    load(7'd9, 1, 32'h11, 1'b0);
    i_ld_start = 1'b1; i_ld_base = 7'd9; i_ld_valid = 1'b1; i_ld_data = 32'h55;
    i_rd_req = 1'b1; i_rd_addr = 7'd9;
    rd_exp_q.push_back(model_mem[9]);
    model_mem[9] = 32'h55;
    tick();
    i_ld_start = 1'b0; i_ld_valid = 1'b0; i_rd_req = 1'b0;
    check_val("collide_ld_count", 64'(o_ld_count), 64'd1);
    rd(7'd9);
    tick();

    // Zero-length stream is ignored.
    i_st_start = 1'b1; i_st_addr = 7'd5; i_st_len = '0;
    tick();
    i_st_start = 1'b0;
    check_val("len0_busy_a", {63'd0, o_busy}, 64'd0);
    tick();
    check_val("len0_busy_b", {63'd0, o_busy}, 64'd0);
    check_val("len0_valid", {63'd0, o_st_valid}, 64'd0);

    // Reset after three transfers of a 16-word stream.
    load(7'd20, 16, 32'hE0, 1'b0);
    check_val("ld_count16", 64'(o_ld_count), 64'd16);
    base_x = st_xfers;
    stream_start(7'd20, 16);
    for (int n = 0; n < 50 && (st_xfers - base_x) < 3; n++) tick();
    check_val("rst_mid_xfers", 64'(st_xfers - base_x), 64'd3);
    reset = 1'b0;
    tick();
    check_val("rst_mid_valid", {63'd0, o_st_valid}, 64'd0);
    check_val("rst_mid_busy", {63'd0, o_busy}, 64'd0);
    check_val("rst_mid_ld_count", 64'(o_ld_count), 64'd0);
    reset = 1'b1;
    st_exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_mid_quiet", {63'd0, o_st_valid}, 64'd0);
    end
    rd(7'd20); rd(7'd6); rd(7'd127);
    tick();
    check_val("final_rd_done", 64'(rd_exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
